// File: rtl/conv_tile_loader_if.sv
// -----------------------------------------------------------------------------
// conv_tile_loader_if
//
// Bundles every non-clock/reset signal of conv_tile_loader:
//   - the 16-bit valid/ready input word stream (s_valid, s_ready, s_data)
//   - the filter-reuse request (keep_filter)
//   - the flat buses presented to the 3x3 PE array (filter_flat, ifmap_flat)
//   - the array control strobes (arr_load, arr_en)
//   - the array result bus (sum_in_flat)
//   - the valid/ready result port (m_valid, m_ready, m_data)
//   - the completed-tile counter (tile_cnt)
//
// Modports:
//   slave  : the loader's view (consumes the stream, produces array/result side)
//   master : the environment's view (upstream source, PE array, downstream sink)
// -----------------------------------------------------------------------------
interface conv_tile_loader_if #(
  parameter int DATA_W  = 16,
  parameter int FILT_N  = 9,
  parameter int IFMAP_N = 25
);

  logic                        s_valid;
  logic                        s_ready;
  logic [DATA_W-1:0]           s_data;
  logic                        keep_filter;
  logic [FILT_N*DATA_W-1:0]    filter_flat;
  logic [IFMAP_N*DATA_W-1:0]   ifmap_flat;
  logic                        arr_load;
  logic                        arr_en;
  logic [FILT_N*DATA_W-1:0]    sum_in_flat;
  logic                        m_valid;
  logic                        m_ready;
  logic [FILT_N*DATA_W-1:0]    m_data;
  logic [7:0]                  tile_cnt;

  modport slave (
    input  s_valid,
    input  s_data,
    input  keep_filter,
    input  sum_in_flat,
    input  m_ready,
    output s_ready,
    output filter_flat,
    output ifmap_flat,
    output arr_load,
    output arr_en,
    output m_valid,
    output m_data,
    output tile_cnt
  );

  modport master (
    output s_valid,
    output s_data,
    output keep_filter,
    output sum_in_flat,
    output m_ready,
    input  s_ready,
    input  filter_flat,
    input  ifmap_flat,
    input  arr_load,
    input  arr_en,
    input  m_valid,
    input  m_data,
    input  tile_cnt
  );

endinterface

// File: rtl/conv_tile_loader.sv
// -----------------------------------------------------------------------------
// conv_tile_loader
//
// Front-end sequencer for the 3x3 PE array. Collects a 3x3 filter followed by
// a 5x5 ifmap tile from a valid/ready word stream, presents both as flat
// buses, pulses arr_load for one cycle, holds arr_en high for COMPUTE_CYCLES
// cycles, captures the array's result bus on the last compute cycle and
// offers it downstream through a valid/ready handshake. No arithmetic is done
// on the data: the block is pure buffering and sequencing.
//
// Ports:
//   clk  : clock, all logic on the rising edge
//   rst  : synchronous, active-high reset; aborts any tile in progress,
//          clears buses, result, counters and tile_cnt
//   bus  : conv_tile_loader_if.slave
//          s_valid/s_ready/s_data : input word stream
//          keep_filter            : reuse held filter for the next tile
//          filter_flat            : filter word k at [k*DATA_W +: DATA_W]
//          ifmap_flat             : ifmap word k at [k*DATA_W +: DATA_W]
//          arr_load               : one-cycle load pulse (array reset)
//          arr_en                 : array enable during the compute window
//          sum_in_flat            : array result bus
//          m_valid/m_ready/m_data : captured result handshake
//          tile_cnt               : completed tiles, wraps 255 -> 0
//
// Parameters:
//   DATA_W         word width
//   FILT_N         filter words per tile
//   IFMAP_N        ifmap words per tile
//   COMPUTE_CYCLES cycles arr_en is held high (legal range 1..255)
//
// Build option:
//   LOADER_FILTER_REUSE_EN - when defined, keep_filter=1 at the output
//   handshake skips the filter load for the next tile and retains
//   filter_flat. When undefined keep_filter is ignored and every tile loads
//   FILT_N filter words followed by IFMAP_N ifmap words.
// -----------------------------------------------------------------------------
module conv_tile_loader #(
  parameter int DATA_W         = 16,
  parameter int FILT_N         = 9,
  parameter int IFMAP_N        = 25,
  parameter int COMPUTE_CYCLES = 12
) (
  input  logic               clk,
  input  logic               rst,
  conv_tile_loader_if.slave  bus
);

  // One word counter serves both load phases, so it is sized for the larger.
  localparam int WORDS_MAX  = (IFMAP_N > FILT_N) ? IFMAP_N : FILT_N;
  localparam int CNT_W      = $clog2(WORDS_MAX);
  localparam int FILT_IDX_W = $clog2(FILT_N);
  localparam int IFM_IDX_W  = $clog2(IFMAP_N);

  typedef enum logic [2:0] {
    LOAD_FILT,
    LOAD_IFMAP,
    ARR_LOAD,
    COMPUTE,
    OUTPUT
  } state_t;

  state_t                              state;
  state_t                              state_next;

  logic [CNT_W-1:0]                    word_cnt;
  logic [7:0]                          comp_cnt;
  logic [FILT_N-1:0][DATA_W-1:0]       filt_q;
  logic [IFMAP_N-1:0][DATA_W-1:0]      ifmap_q;
  logic [FILT_N*DATA_W-1:0]            result_q;
  logic [7:0]                          tile_cnt_q;

  logic                                load_state;
  logic                                ready;
  logic                                accept;
  logic                                filt_last;
  logic                                ifmap_last;
  logic                                comp_last;
  logic                                out_fire;
  logic                                reuse;
  logic                                arr_load;
  logic                                arr_en;
  logic                                m_valid;

  // Handshake qualifiers are decoded straight from the state register so the
  // FSM's combinational process never reads its own outputs back.
  assign load_state = (state == LOAD_FILT) || (state == LOAD_IFMAP);
  assign ready      = load_state && !rst;
  assign accept     = ready && bus.s_valid;
  assign out_fire   = (state == OUTPUT) && !rst && bus.m_ready;

  assign filt_last  = (word_cnt == CNT_W'(FILT_N - 1));
  assign ifmap_last = (word_cnt == CNT_W'(IFMAP_N - 1));
  assign comp_last  = (comp_cnt == 8'(COMPUTE_CYCLES - 1));

`ifdef LOADER_FILTER_REUSE_EN
  assign reuse = bus.keep_filter;
`else
  logic unused_keep_filter;
  assign unused_keep_filter = bus.keep_filter;
  assign reuse              = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LOAD_FILT;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and control outputs. Control strobes are forced low while
  // rst is high so an abort takes effect in the same cycle.
  always_comb begin
    state_next = state;
    arr_load   = 1'b0;
    arr_en     = 1'b0;
    m_valid    = 1'b0;
    case (state)
      LOAD_FILT: begin
        if (accept && filt_last) begin
          state_next = LOAD_IFMAP;
        end
      end
      LOAD_IFMAP: begin
        if (accept && ifmap_last) begin
          state_next = ARR_LOAD;
        end
      end
      ARR_LOAD: begin
        arr_load   = !rst;
        state_next = COMPUTE;
      end
      COMPUTE: begin
        arr_en = !rst;
        if (comp_last) begin
          state_next = OUTPUT;
        end
      end
      OUTPUT: begin
        m_valid = !rst;
        if (out_fire) begin
          state_next = reuse ? LOAD_IFMAP : LOAD_FILT;
        end
      end
      default: begin
        state_next = LOAD_FILT;
      end
    endcase
  end

  // Word buffers, counters and result capture. Each slot is written only when
  // its own word is accepted, so the buses hold their contents outside the
  // load states (and the filter survives a reuse tile untouched).
  always_ff @(posedge clk) begin
    if (rst) begin
      word_cnt   <= '0;
      comp_cnt   <= '0;
      filt_q     <= '0;
      ifmap_q    <= '0;
      result_q   <= '0;
      tile_cnt_q <= '0;
    end else begin
      case (state)
        LOAD_FILT: begin
          if (accept) begin
            filt_q[word_cnt[FILT_IDX_W-1:0]] <= bus.s_data;
            word_cnt <= filt_last ? '0 : word_cnt + CNT_W'(1);
          end
        end
        LOAD_IFMAP: begin
          if (accept) begin
            ifmap_q[word_cnt[IFM_IDX_W-1:0]] <= bus.s_data;
            word_cnt <= ifmap_last ? '0 : word_cnt + CNT_W'(1);
          end
        end
        ARR_LOAD: begin
          comp_cnt <= '0;
        end
        COMPUTE: begin
          // The array has had COMPUTE_CYCLES enabled cycles by the end of
          // this cycle, so its result bus is final here.
          if (comp_last) begin
            result_q <= bus.sum_in_flat;
          end else begin
            comp_cnt <= comp_cnt + 8'd1;
          end
        end
        OUTPUT: begin
          if (out_fire) begin
            tile_cnt_q <= tile_cnt_q + 8'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.s_ready     = ready;
  assign bus.arr_load    = arr_load;
  assign bus.arr_en      = arr_en;
  assign bus.m_valid     = m_valid;
  assign bus.filter_flat = filt_q;
  assign bus.ifmap_flat  = ifmap_q;
  assign bus.m_data      = result_q;
  assign bus.tile_cnt    = tile_cnt_q;

endmodule
